// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: user-side request/response handshake of sram_access_ctrl.
// master = requester, slave = controller.
interface sram_access_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned WORD_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [WORD_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: one-request-at-a-time SRAM sequencer (precharge, wordline, write/sense, recover).
// Optional even-parity bit on the bitlines when SRAM_ACCESS_CTRL_PARITY_EN is defined.
module sram_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_ROWS   = 64,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned PRE_CYCLES = 2,
    parameter int unsigned ACC_CYCLES = 2,
`ifdef SRAM_ACCESS_CTRL_PARITY_EN
    localparam int unsigned PW = WORD_WIDTH + 1
`else
    localparam int unsigned PW = WORD_WIDTH
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_access_ctrl_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] row_addr,
    output logic                  row_en,
    output logic                  precharge_en,
    output logic                  write_en,
    output logic                  sense_en,
    output logic [PW-1:0]         bl_wdata,
    input  logic [PW-1:0]         bl_rdata
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRECHARGE = 2'd1;
    localparam logic [1:0] ACCESS    = 2'd2;
    localparam logic [1:0] RECOVER   = 2'd3;

    localparam int unsigned CNT_MAX = (PRE_CYCLES > ACC_CYCLES) ? PRE_CYCLES : ACC_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  inr_q, inr_d;
    logic [PW-1:0]         wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic                  row_en_q, row_en_d;
    logic                  precharge_en_q, precharge_en_d;
    logic                  write_en_q, write_en_d;
    logic                  sense_en_q, sense_en_d;
    logic [PW-1:0]         bl_wdata_q, bl_wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [WORD_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic          addr_in_range;
    logic [PW-1:0] wdata_ext;
    logic          parity_bad;

    assign addr_in_range = {1'b0, bus.req_addr} < (ADDR_WIDTH + 1)'(NUM_ROWS);

`ifdef SRAM_ACCESS_CTRL_PARITY_EN
    assign wdata_ext  = {^bus.req_wdata, bus.req_wdata};
    assign parity_bad = ^bl_rdata;
`else
    assign wdata_ext  = bus.req_wdata;
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        inr_d       = inr_q;
        wdata_d     = wdata_q;
        row_addr_d  = row_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d    = PRECHARGE;
                    cnt_d      = '0;
                    we_d       = bus.req_we;
                    inr_d      = addr_in_range;
                    wdata_d    = wdata_ext;
                    row_addr_d = bus.req_addr;
                end
            end
            PRECHARGE: begin
                if (cnt_q == CW'(PRE_CYCLES - 1)) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACCESS: begin
                if (cnt_q == CW'(ACC_CYCLES - 1)) begin
                    state_d   = RECOVER;
                    cnt_d     = '0;
                    rsp_err_d = !inr_q || (!we_q && parity_bad);
                    // Sense-amp outputs are captured on the edge that ends the strobe cycle.
                    if (!we_q) begin
                        rsp_rdata_d = inr_q ? bl_rdata[WORD_WIDTH-1:0] : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    always_comb begin
        req_ready_d    = (state_d == IDLE);
        precharge_en_d = (state_d == PRECHARGE) && inr_d;
        row_en_d       = (state_d == ACCESS) && inr_d;
        write_en_d     = row_en_d && we_d;
        sense_en_d     = row_en_d && !we_d && (cnt_d == CW'(ACC_CYCLES - 1));
        bl_wdata_d     = write_en_d ? wdata_d : '0;
        rsp_valid_d    = (state_d == RECOVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            we_q           <= 1'b0;
            inr_q          <= 1'b0;
            wdata_q        <= '0;
            row_addr_q     <= '0;
            row_en_q       <= 1'b0;
            precharge_en_q <= 1'b0;
            write_en_q     <= 1'b0;
            sense_en_q     <= 1'b0;
            bl_wdata_q     <= '0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            inr_q          <= inr_d;
            wdata_q        <= wdata_d;
            row_addr_q     <= row_addr_d;
            row_en_q       <= row_en_d;
            precharge_en_q <= precharge_en_d;
            write_en_q     <= write_en_d;
            sense_en_q     <= sense_en_d;
            bl_wdata_q     <= bl_wdata_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign row_addr      = row_addr_q;
    assign row_en        = row_en_q;
    assign precharge_en  = precharge_en_q;
    assign write_en      = write_en_q;
    assign sense_en      = sense_en_q;
    assign bl_wdata      = bl_wdata_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: two controllers (NUM_ROWS 64 and 48) driven by identical requests,
// checked cycle by cycle against a transaction-level timing and memory model.
module tb_sram_access_ctrl;
    localparam int AW   = 6;
    localparam int WW   = 8;
    localparam int PRE  = 2;
    localparam int ACC  = 2;
    localparam int NR_A = 64;
    localparam int NR_B = 48;
    localparam int LAT  = PRE + ACC + 1;
`ifdef SRAM_ACCESS_CTRL_PARITY_EN
    localparam int PW = WW + 1;
`else
    localparam int PW = WW;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          req_valid, req_we;
    logic [AW-1:0] req_addr;
    logic [WW-1:0] req_wdata;

    sram_access_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus_a ();
    sram_access_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus_b ();
    assign bus_a.req_valid = req_valid;
    assign bus_a.req_we    = req_we;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_we    = req_we;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_wdata = req_wdata;

    logic [AW-1:0] row_addr_a, row_addr_b;
    logic          row_en_a, row_en_b, precharge_en_a, precharge_en_b;
    logic          write_en_a, write_en_b, sense_en_a, sense_en_b;
    logic [PW-1:0] bl_wdata_a, bl_wdata_b, bl_rdata_a, bl_rdata_b;

    // Behavioural SRAM array, written only by controller A's strobes.
    logic [PW-1:0] arr [64];
    assign bl_rdata_a = arr[row_addr_a];
    assign bl_rdata_b = arr[row_addr_b];
    always @(posedge clk) if (row_en_a && write_en_a) arr[row_addr_a] <= bl_wdata_a;

    sram_access_ctrl #(.ADDR_WIDTH(AW), .NUM_ROWS(NR_A), .WORD_WIDTH(WW),
                       .PRE_CYCLES(PRE), .ACC_CYCLES(ACC)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .row_addr(row_addr_a), .row_en(row_en_a),
        .precharge_en(precharge_en_a), .write_en(write_en_a), .sense_en(sense_en_a),
        .bl_wdata(bl_wdata_a), .bl_rdata(bl_rdata_a));

    sram_access_ctrl #(.ADDR_WIDTH(AW), .NUM_ROWS(NR_B), .WORD_WIDTH(WW),
                       .PRE_CYCLES(PRE), .ACC_CYCLES(ACC)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .row_addr(row_addr_b), .row_en(row_en_b),
        .precharge_en(precharge_en_b), .write_en(write_en_b), .sense_en(sense_en_b),
        .bl_wdata(bl_wdata_b), .bl_rdata(bl_rdata_b));

    int n_assert = 0;
    int n_fail   = 0;

    logic [PW-1:0] ref_mem [64];
    bit            ref_ok  [64];
    logic [WW-1:0] last_rd_a, last_rd_b;
    int            last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_word(input logic [WW-1:0] d, input bit flip);
        logic [PW-1:0] w;
        w = PW'(d);
`ifdef SRAM_ACCESS_CTRL_PARITY_EN
        w[WW] = (($countones(d) % 2) == 1) ^ flip;
`else
        if (flip) w = PW'(d);
`endif
        return w;
    endfunction

    // k = cycle index after the accept edge (1 .. LAT)
    task automatic check_cycle(input string who, input int k, input bit we, input bit inr,
                               input logic [AW-1:0] addr, input logic [PW-1:0] w,
                               input logic pre, input logic row, input logic wr, input logic se,
                               input logic rv, input logic rdy, input logic [AW-1:0] ra,
                               input logic [PW-1:0] bw);
        bit e_pre, e_acc;
        e_pre = inr && (k <= PRE);
        e_acc = inr && (k > PRE) && (k <= PRE + ACC);
        check({who, ".precharge_en"}, 32'(pre), 32'(e_pre));
        check({who, ".row_en"},       32'(row), 32'(e_acc));
        check({who, ".write_en"},     32'(wr),  32'(e_acc && we));
        check({who, ".sense_en"},     32'(se),  32'(inr && !we && (k == PRE + ACC)));
        check({who, ".rsp_valid"},    32'(rv),  32'(k == LAT));
        check({who, ".req_ready"},    32'(rdy), 32'(0));
        check({who, ".row_addr"},     32'(ra),  32'(addr));
        check({who, ".excl_pre_row"}, 32'(pre && row), 32'(0));
        check({who, ".excl_wr_se"},   32'(wr && se), 32'(0));
        check({who, ".strobe_no_row"}, 32'((wr || se) && !row), 32'(0));
        if (e_acc && we) check({who, ".bl_wdata"}, 32'(bw), 32'(w));
    endtask

    task automatic txn(input bit we, input logic [AW-1:0] addr, input logic [WW-1:0] data,
                       input bit hold, input bit chk_gap, input bit abort);
        bit            got, inr_b, e_err_a, e_err_b;
        logic [PW-1:0] w;
        logic [WW-1:0] e_rd_a, e_rd_b;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus_a.req_ready === 1'b1) got = 1'b1;
            @(posedge clk); #1;
        end
        if (!got) begin
            check("accept_timeout", 32'(0), 32'(1));
            req_valid = 1'b0;
            return;
        end
        if (chk_gap) check("throughput_gap", 32'(cyc - last_acc), 32'(PRE + ACC + 2));
        last_acc = cyc;
        w     = mk_word(data, 1'b0);
        inr_b = int'(addr) < NR_B;
        for (int k = 1; k <= LAT; k++) begin
            check_cycle("A", k, we, 1'b1, addr, w, precharge_en_a, row_en_a, write_en_a,
                        sense_en_a, bus_a.rsp_valid, bus_a.req_ready, row_addr_a, bl_wdata_a);
            check_cycle("B", k, we, inr_b, addr, w, precharge_en_b, row_en_b, write_en_b,
                        sense_en_b, bus_b.rsp_valid, bus_b.req_ready, row_addr_b, bl_wdata_b);
            if (abort && k == PRE + 1) begin
                rst = 1'b1; req_valid = 1'b0;
                #1;
                check("abort.row_en",   32'(row_en_a || row_en_b), 32'(0));
                check("abort.write_en", 32'(write_en_a || write_en_b), 32'(0));
                check("abort.rsp_valid", 32'(bus_a.rsp_valid || bus_b.rsp_valid), 32'(0));
                repeat (2) @(posedge clk);
                @(negedge clk) rst = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    @(posedge clk); #1;
                    check("abort.no_rsp", 32'(bus_a.rsp_valid || bus_b.rsp_valid), 32'(0));
                end
                check("abort.rsp_rdata", 32'(bus_a.rsp_rdata), 32'(0));
                ref_ok[addr] = 1'b0;
                last_rd_a = '0; last_rd_b = '0;
                return;
            end
            if (k == 1) req_valid = hold;
            if (k < LAT) begin
                req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = WW'($urandom);
                @(posedge clk); #1;
            end
        end
        if (we) begin
            e_err_a = 1'b0; e_err_b = !inr_b; e_rd_a = last_rd_a; e_rd_b = last_rd_b;
        end else begin
            e_rd_a = ref_mem[addr][WW-1:0];
`ifdef SRAM_ACCESS_CTRL_PARITY_EN
            e_err_a = ($countones(ref_mem[addr][WW-1:0]) % 2) != int'(ref_mem[addr][WW]);
`else
            e_err_a = 1'b0;
`endif
            e_rd_b  = inr_b ? e_rd_a : '0;
            e_err_b = inr_b ? e_err_a : 1'b1;
        end
        check("A.rsp_err",   32'(bus_a.rsp_err),   32'(e_err_a));
        check("B.rsp_err",   32'(bus_b.rsp_err),   32'(e_err_b));
        check("A.rsp_rdata", 32'(bus_a.rsp_rdata), 32'(e_rd_a));
        check("B.rsp_rdata", 32'(bus_b.rsp_rdata), 32'(e_rd_b));
        if (we) begin
            ref_mem[addr] = w; ref_ok[addr] = 1'b1;
        end else begin
            last_rd_a = e_rd_a; last_rd_b = e_rd_b;
        end
        @(posedge clk); #1;
        check("A.idle_ready", 32'(bus_a.req_ready), 32'(1));
        check("B.idle_ready", 32'(bus_b.req_ready), 32'(1));
        check("A.idle_rsp_valid", 32'(bus_a.rsp_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] d;
        bit            we, flip;
        logic [AW-1:0] a;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        last_rd_a = '0; last_rd_b = '0; last_acc = 0;
        for (int i = 0; i < 64; i++) begin
            d = WW'($urandom);
            flip = ($urandom_range(0, 7) == 0);
            ref_mem[i] = mk_word(d, flip); arr[i] = mk_word(d, flip); ref_ok[i] = 1'b1;
        end
        #1 rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst.req_ready", 32'(bus_a.req_ready || bus_b.req_ready), 32'(0));
            check("rst.strobes", 32'({precharge_en_a, row_en_a, write_en_a, sense_en_a,
                                      precharge_en_b, row_en_b, write_en_b, sense_en_b}), 32'(0));
            check("rst.rsp", 32'({bus_a.rsp_valid, bus_a.rsp_err, bus_a.rsp_rdata}), 32'(0));
            check("rst.row_addr", 32'({row_addr_a, row_addr_b}), 32'(0));
            check("rst.bl_wdata", 32'(bl_wdata_a), 32'(0));
        end
        @(negedge clk) rst = 1'b0;
        #1 check("rst.ready_before_edge", 32'(bus_a.req_ready), 32'(0));
        @(posedge clk); #1;
        check("rst.ready_first_edge", 32'(bus_a.req_ready && bus_b.req_ready), 32'(1));
        check("rst.no_accept", 32'(precharge_en_a), 32'(0));
        req_valid = 1'b0;

        txn(1'b1, 6'd5, 8'hA5, 1'b0, 1'b0, 1'b0);
        ref_mem[63] = mk_word(8'h3C, 1'b0); arr[63] = mk_word(8'h3C, 1'b0);
        txn(1'b0, 6'd63, 8'h00, 1'b0, 1'b0, 1'b0);
        txn(1'b0, 6'd63, 8'h00, 1'b1, 1'b0, 1'b0);
        txn(1'b0, 6'd10, 8'h00, 1'b1, 1'b1, 1'b0);
        txn(1'b0, 6'd5,  8'h00, 1'b0, 1'b1, 1'b0);
        txn(1'b0, 6'd50, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef SRAM_ACCESS_CTRL_PARITY_EN
        txn(1'b1, 6'd7, 8'h07, 1'b0, 1'b0, 1'b0);
        ref_mem[9] = 9'h007; arr[9] = 9'h007;
        txn(1'b0, 6'd9, 8'h00, 1'b0, 1'b0, 1'b0);
`endif
        txn(1'b1, 6'd20, 8'h5A, 1'b0, 1'b0, 1'b1);
        txn(1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom);
            a  = AW'($urandom);
            if (!ref_ok[a]) we = 1'b1;
            txn(we, a, WW'($urandom), (i < 39) && 1'($urandom), 1'b0, 1'b0);
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Sequences one SRAM macro per request: precharge, wordline activation through row_decoder, write-drive or sense, then recovery. Sits between the user-side request/response handshake and the array datapath (row_decoder, bitline drivers, sense amps). Serves one request at a time and enforces parameterised timing. Guarantees precharge and wordline are never active together.

Parameters:
ADDR_WIDTH, 6, row address width; drives row_decoder addr.
NUM_ROWS, 64, implemented rows; must be <= 2**ADDR_WIDTH.
WORD_WIDTH, 8, data bits per row.
PRE_CYCLES, 2, precharge duration in clk cycles; must be >= 1.
ACC_CYCLES, 2, wordline-active duration in cycles; must be >= 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  row address.
req_wdata  in  WORD_WIDTH  write data.
rsp_valid  out  1  one-cycle pulse: request completed.
rsp_rdata  out  WORD_WIDTH  read data; held until the next read completes.
rsp_err  out  1  qualified by rsp_valid: address out of range (or parity error).
row_addr  out  ADDR_WIDTH  to row_decoder addr.
row_en  out  1  to row_decoder enable (wordline on).
precharge_en  out  1  bitline precharge.
write_en  out  1  write drivers on.
sense_en  out  1  sense-amp strobe.
bl_wdata  out  PW  bitline write data.
bl_rdata  in  PW  sense-amp outputs.
PW = WORD_WIDTH, or WORD_WIDTH+1 with the optional feature.

Behaviour:
- All outputs are registered. While rst is high, every output is 0 and the FSM is in IDLE. req_ready first goes to 1 on the first clk edge after rst falls.
- FSM states and transitions:
  - IDLE: req_ready=1. A request is accepted on an edge where req_valid&req_ready. The block latches we/addr/wdata, drops req_ready and goes to PRECHARGE.
  - PRECHARGE: precharge_en=1 for exactly PRE_CYCLES cycles, then ACCESS.
  - ACCESS: row_en=1 for exactly ACC_CYCLES cycles.
    - Write: write_en=1 for all ACC_CYCLES cycles; bl_wdata = latched data.
    - Read: sense_en=1 only in the last ACCESS cycle; bl_rdata is captured at the end of that cycle.
    - Then RECOVER.
  - RECOVER: all array strobes are 0 and rsp_valid=1 for one cycle; rsp_rdata is updated for reads. Next state is IDLE.
- Latency: rsp_valid is asserted PRE_CYCLES+ACC_CYCLES+1 cycles after the accept edge. Back-to-back throughput is one request per PRE_CYCLES+ACC_CYCLES+2 cycles.
- row_addr is stable from PRECHARGE through RECOVER. It holds its last value in IDLE and is 0 after reset.
- Strobe exclusivity:
  - precharge_en and row_en are never both 1.
  - write_en and sense_en are never both 1.
  - write_en and sense_en are only 1 while row_en is 1.
- Out-of-range address (req_addr >= NUM_ROWS):
  - The request is still accepted and walks through all states with the same timing.
  - row_en, write_en, sense_en and precharge_en stay 0.
  - At RECOVER: rsp_err=1; for a read, rsp_rdata = 0.
- Changes on req_* while not in IDLE are ignored. The block has no queueing.
- An rst assertion mid-operation aborts immediately and asynchronously: all strobes drop and no rsp_valid is produced for the aborted request. A partial write leaves array contents undefined.
- rsp_rdata retains its value across writes. It is reset to 0 only by rst.

Optional Feature:
SRAM_ACCESS_CTRL_PARITY_EN.
- Defined: PW = WORD_WIDTH+1. On writes, bl_wdata[WORD_WIDTH] = XOR of req_wdata (even parity). On reads, the controller recomputes parity over bl_rdata[WORD_WIDTH-1:0] and compares it with bl_rdata[WORD_WIDTH]. A mismatch sets rsp_err=1 while rsp_rdata still returns the data bits.
- Undefined: PW = WORD_WIDTH, and rsp_err flags only out-of-range addresses.

Test Plan:
- Reset: hold rst for 3 cycles with req_valid=1 -> all outputs 0, no accept. On the first edge after release, req_ready=1.
- Write addr=5, data=0xA5 (defaults) -> precharge_en high 2 cycles, then row_addr=5, row_en and write_en high 2 cycles with bl_wdata=0xA5. rsp_valid pulses 5 cycles after accept with rsp_err=0; sense_en never asserted.
- Read addr=63 with the array model returning 0x3C -> sense_en only in the second ACCESS cycle, rsp_rdata=0x3C, rsp_valid 5 cycles after accept. Back-to-back reads with req_valid held are accepted every 6 cycles.
- NUM_ROWS=48, read addr=50 -> no row_en, write_en, sense_en or precharge_en; rsp_valid after 5 cycles with rsp_err=1, rsp_rdata=0.
- Assert rst during the first ACCESS cycle of a write -> row_en and write_en drop in the same cycle, no rsp_valid. After release, a read of addr 0 completes normally.
- With SRAM_ACCESS_CTRL_PARITY_EN defined:
  - Write 0x07 -> bl_wdata=0x107.
  - Read returning 0x007 -> rsp_err=1, rsp_rdata=0x07.
